// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - bus bundle between the two masters, the arbiter and the three slaves
interface wb_arbiter_if;
    logic        m_mmu_cyc,    m_dma_cyc;
    logic        m_mmu_we,     m_dma_we;
    logic [3:0]  m_mmu_strb,   m_dma_strb;
    logic [31:0] m_mmu_addr,   m_dma_addr;
    logic [31:0] m_mmu_data_i, m_dma_data_i;
    logic        m_mmu_ack,    m_dma_ack;
    logic        m_mmu_err,    m_dma_err;
    logic [31:0] m_mmu_data_o, m_dma_data_o;

    logic        s_mem_cyc, s_dma_cyc, s_key_cyc;
    logic        s_we;
    logic [3:0]  s_strb;
    logic [31:0] s_addr, s_data_o;
    logic        s_mem_ack, s_dma_ack, s_key_ack;
    logic [31:0] s_mem_data_i, s_dma_data_i, s_key_data_i;

    // Arbiter view: it answers the masters and drives the shared slave path.
    modport slave (
        input  m_mmu_cyc, m_dma_cyc, m_mmu_we, m_dma_we, m_mmu_strb, m_dma_strb,
               m_mmu_addr, m_dma_addr, m_mmu_data_i, m_dma_data_i,
               s_mem_ack, s_dma_ack, s_key_ack, s_mem_data_i, s_dma_data_i, s_key_data_i,
        output m_mmu_ack, m_dma_ack, m_mmu_err, m_dma_err, m_mmu_data_o, m_dma_data_o,
               s_mem_cyc, s_dma_cyc, s_key_cyc, s_we, s_strb, s_addr, s_data_o
    );

    // Environment view: the masters issuing requests and the slaves answering them.
    modport master (
        output m_mmu_cyc, m_dma_cyc, m_mmu_we, m_dma_we, m_mmu_strb, m_dma_strb,
               m_mmu_addr, m_dma_addr, m_mmu_data_i, m_dma_data_i,
               s_mem_ack, s_dma_ack, s_key_ack, s_mem_data_i, s_dma_data_i, s_key_data_i,
        input  m_mmu_ack, m_dma_ack, m_mmu_err, m_dma_err, m_mmu_data_o, m_dma_data_o,
               s_mem_cyc, s_dma_cyc, s_key_cyc, s_we, s_strb, s_addr, s_data_o
    );
endinterface

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - two-master round-robin arbiter and three-slave decoder with error/timeout termination
module wb_arbiter #(
    parameter logic [31:0] MEM_LIMIT = 32'h0000_8000,
    parameter logic [19:0] KEY_PAGE  = 20'h0000E,
    parameter logic [19:0] DMA_PAGE  = 20'h0000F,
    parameter int          TIMEOUT   = 16
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);
    localparam int WCW = $clog2(TIMEOUT);
    localparam logic [1:0] SEL_MEM = 2'd0;
    localparam logic [1:0] SEL_DMA = 2'd1;
    localparam logic [1:0] SEL_KEY = 2'd2;

    typedef enum logic [1:0] {IDLE, GNT, ERR} state_t;

    state_t         state, state_nxt;
    logic           gnt_id, last_id;
    logic [1:0]     sel;
    logic [WCW-1:0] wait_cnt;

    logic        any_req, winner;
    logic [31:0] win_addr;
    logic        is_mem, is_key, is_dma, mapped;
    logic [1:0]  win_sel;

    logic        g_cyc, g_we;
    logic [3:0]  g_strb;
    logic [31:0] g_addr, g_data;
    logic        sel_ack;
    logic [31:0] sel_data;
    logic        ack_g, err_g;
    logic [31:0] data_g;

    // On a tie the master that did not win last time takes the bus.
    assign any_req  = bus.m_mmu_cyc | bus.m_dma_cyc;
    assign winner   = (bus.m_mmu_cyc & bus.m_dma_cyc) ? ~last_id : bus.m_dma_cyc;
    assign win_addr = winner ? bus.m_dma_addr : bus.m_mmu_addr;

    assign is_mem  = win_addr < MEM_LIMIT;
    assign is_key  = win_addr[31:12] == KEY_PAGE;
    assign is_dma  = win_addr[31:12] == DMA_PAGE;
    assign mapped  = is_mem | is_key | is_dma;
    assign win_sel = is_mem ? SEL_MEM : (is_key ? SEL_KEY : SEL_DMA);

    assign g_cyc  = gnt_id ? bus.m_dma_cyc    : bus.m_mmu_cyc;
    assign g_we   = gnt_id ? bus.m_dma_we     : bus.m_mmu_we;
    assign g_strb = gnt_id ? bus.m_dma_strb   : bus.m_mmu_strb;
    assign g_addr = gnt_id ? bus.m_dma_addr   : bus.m_mmu_addr;
    assign g_data = gnt_id ? bus.m_dma_data_i : bus.m_mmu_data_i;

    always_comb begin
        sel_ack  = 1'b0;
        sel_data = 32'h0;
        case (sel)
            SEL_MEM: begin sel_ack = bus.s_mem_ack; sel_data = bus.s_mem_data_i; end
            SEL_DMA: begin sel_ack = bus.s_dma_ack; sel_data = bus.s_dma_data_i; end
            SEL_KEY: begin sel_ack = bus.s_key_ack; sel_data = bus.s_key_data_i; end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        ack_g         = 1'b0;
        err_g         = 1'b0;
        data_g        = 32'h0;
        bus.s_mem_cyc = 1'b0;
        bus.s_dma_cyc = 1'b0;
        bus.s_key_cyc = 1'b0;
        bus.s_we      = 1'b0;
        bus.s_strb    = 4'h0;
        bus.s_addr    = 32'h0;
        bus.s_data_o  = 32'h0;
        case (state)
            IDLE: if (any_req) state_nxt = mapped ? GNT : ERR;
            GNT: begin
                // Dropping cyc mid-transfer aborts silently: no ack, no err.
                if (g_cyc) begin
                    bus.s_mem_cyc = (sel == SEL_MEM);
                    bus.s_dma_cyc = (sel == SEL_DMA);
                    bus.s_key_cyc = (sel == SEL_KEY);
                    bus.s_we      = g_we;
                    bus.s_strb    = g_strb;
                    bus.s_addr    = g_addr;
                    bus.s_data_o  = g_data;
                    data_g        = sel_data;
                    if (sel_ack) begin
                        ack_g     = 1'b1;
                        state_nxt = IDLE;
                    end else if (wait_cnt == WCW'(TIMEOUT - 1)) begin
                        err_g     = 1'b1;
                        state_nxt = IDLE;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            ERR: begin
                err_g     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        bus.m_mmu_ack    = ack_g & ~gnt_id;
        bus.m_dma_ack    = ack_g &  gnt_id;
        bus.m_mmu_err    = err_g & ~gnt_id;
        bus.m_dma_err    = err_g &  gnt_id;
        bus.m_mmu_data_o = gnt_id ? 32'h0 : data_g;
        bus.m_dma_data_o = gnt_id ? data_g : 32'h0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt_id   <= 1'b0;
            last_id  <= 1'b1;
            sel      <= SEL_MEM;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                gnt_id   <= winner;
                wait_cnt <= '0;
                if (mapped) begin
                    sel     <= win_sel;
                    last_id <= winner;
                end
            end else if (state == GNT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic auto_ack = 1'b0;
    logic mem_ack = 1'b0, dma_ack = 1'b0, key_ack = 1'b0;

    wb_arbiter_if bus();

    wb_arbiter #(.TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    assign bus.s_mem_ack = auto_ack ? bus.s_mem_cyc : mem_ack;
    assign bus.s_dma_ack = auto_ack ? bus.s_dma_cyc : dma_ack;
    assign bus.s_key_ack = auto_ack ? bus.s_key_cyc : key_ack;

    function automatic logic [139:0] all_outputs();
        return {bus.m_mmu_ack, bus.m_dma_ack, bus.m_mmu_err, bus.m_dma_err,
                bus.s_mem_cyc, bus.s_dma_cyc, bus.s_key_cyc, bus.s_we, bus.s_strb,
                bus.s_addr, bus.s_data_o, bus.m_mmu_data_o, bus.m_dma_data_o};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (all_outputs() !== 140'h0) begin
            bad++;
            $display("FAIL reset_outputs actual=%h required=0", all_outputs());
        end
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_mmu_read();
        step();
        bus.m_mmu_cyc = 1'b1; bus.m_mmu_we = 1'b0; bus.m_mmu_addr = 32'h0000_0100; bus.m_mmu_strb = 4'hF;
        @(negedge clk);
        total++;
        if (bus.s_mem_cyc !== 1'b0) begin bad++; $display("FAIL read_cyc_n actual=%b required=0", bus.s_mem_cyc); end
        step();
        @(negedge clk);
        total++;
        if ({bus.s_mem_cyc, bus.s_dma_cyc, bus.s_key_cyc, bus.m_mmu_ack} !== 4'b1000) begin
            bad++; $display("FAIL read_cyc_n1 actual=%b required=1000", {bus.s_mem_cyc, bus.s_dma_cyc, bus.s_key_cyc, bus.m_mmu_ack});
        end
        step();
        @(negedge clk);
        total++;
        if ({bus.s_mem_cyc, bus.m_mmu_ack} !== 2'b10) begin
            bad++; $display("FAIL read_wait actual=%b required=10", {bus.s_mem_cyc, bus.m_mmu_ack});
        end
        step();
        mem_ack = 1'b1; bus.s_mem_data_i = 32'hDEAD_BEEF;
        @(negedge clk);
        total++;
        if ({bus.m_mmu_ack, bus.m_mmu_err, bus.m_mmu_data_o} !== {2'b10, 32'hDEAD_BEEF}) begin
            bad++; $display("FAIL read_ack actual=%b%b %h required=10 deadbeef", bus.m_mmu_ack, bus.m_mmu_err, bus.m_mmu_data_o);
        end
        total++;
        if ({bus.m_dma_ack, bus.m_dma_err, bus.m_dma_data_o} !== 34'h0) begin
            bad++; $display("FAIL read_dma_quiet actual=%h required=0", {bus.m_dma_ack, bus.m_dma_err, bus.m_dma_data_o});
        end
        step();
        bus.m_mmu_cyc = 1'b0; mem_ack = 1'b0; bus.s_mem_data_i = 32'h0;
        @(negedge clk);
        total++;
        if ({bus.s_mem_cyc, bus.m_mmu_ack} !== 2'b00) begin
            bad++; $display("FAIL read_done actual=%b required=00", {bus.s_mem_cyc, bus.m_mmu_ack});
        end
    endtask

    task automatic test_round_robin();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        auto_ack = 1'b1;
        bus.m_mmu_cyc = 1'b1; bus.m_mmu_addr = 32'h0000_0200;
        bus.m_dma_cyc = 1'b1; bus.m_dma_addr = 32'h0000_0300;
        for (int i = 0; i < 8; i++) begin
            step();
            @(negedge clk);
            total++;
            if ({bus.m_mmu_ack, bus.m_dma_ack} !== {i % 4 == 0, i % 4 == 2}) begin
                bad++; $display("FAIL rr_grant_%0d actual=%b required=%b", i, {bus.m_mmu_ack, bus.m_dma_ack}, {i % 4 == 0, i % 4 == 2});
            end
        end
        bus.m_mmu_cyc = 1'b0; bus.m_dma_cyc = 1'b0;
        auto_ack = 1'b0;
    endtask

    task automatic test_key_write();
        step();
        bus.m_dma_cyc = 1'b1; bus.m_dma_we = 1'b1; bus.m_dma_strb = 4'b0011;
        bus.m_dma_addr = 32'h0000_E004; bus.m_dma_data_i = 32'h1234_5678;
        step();
        @(negedge clk);
        total++;
        if ({bus.s_mem_cyc, bus.s_dma_cyc, bus.s_key_cyc, bus.s_we, bus.s_strb} !== 8'b0011_0011) begin
            bad++; $display("FAIL key_cyc actual=%b required=00110011", {bus.s_mem_cyc, bus.s_dma_cyc, bus.s_key_cyc, bus.s_we, bus.s_strb});
        end
        total++;
        if ({bus.s_addr, bus.s_data_o, bus.m_dma_ack} !== {32'h0000_E004, 32'h1234_5678, 1'b0}) begin
            bad++; $display("FAIL key_req actual=%h %h %b required=0000e004 12345678 0", bus.s_addr, bus.s_data_o, bus.m_dma_ack);
        end
        step();
        key_ack = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.m_dma_ack, bus.m_mmu_ack, bus.m_dma_err} !== 3'b100) begin
            bad++; $display("FAIL key_ack actual=%b required=100", {bus.m_dma_ack, bus.m_mmu_ack, bus.m_dma_err});
        end
        step();
        key_ack = 1'b0; bus.m_dma_cyc = 1'b0; bus.m_dma_we = 1'b0;
        @(negedge clk);
        total++;
        if (bus.s_key_cyc !== 1'b0) begin bad++; $display("FAIL key_done actual=%b required=0", bus.s_key_cyc); end
    endtask

    task automatic test_unmapped();
        step();
        bus.m_mmu_cyc = 1'b1; bus.m_mmu_addr = 32'h0001_0000;
        step();
        @(negedge clk);
        total++;
        if ({bus.m_mmu_err, bus.m_mmu_ack, bus.s_mem_cyc, bus.s_dma_cyc, bus.s_key_cyc, bus.m_dma_err} !== 6'b100000) begin
            bad++; $display("FAIL unmapped_err actual=%b required=100000",
                {bus.m_mmu_err, bus.m_mmu_ack, bus.s_mem_cyc, bus.s_dma_cyc, bus.s_key_cyc, bus.m_dma_err});
        end
        step();
        bus.m_mmu_cyc = 1'b0;
        @(negedge clk);
        total++;
        if (bus.m_mmu_err !== 1'b0) begin bad++; $display("FAIL unmapped_one_cycle actual=%b required=0", bus.m_mmu_err); end
    endtask

    task automatic test_timeout(input logic ack_last);
        step();
        bus.m_mmu_cyc = 1'b1; bus.m_mmu_addr = 32'h0000_0300;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 16 && ack_last) mem_ack = 1'b1;
            @(negedge clk);
            total++;
            if ({bus.s_mem_cyc, bus.m_mmu_ack, bus.m_mmu_err} !== {1'b1, k == 16 && ack_last, k == 16 && !ack_last}) begin
                bad++; $display("FAIL timeout_%0d_n%0d actual=%b required=%b", ack_last, k,
                    {bus.s_mem_cyc, bus.m_mmu_ack, bus.m_mmu_err}, {1'b1, k == 16 && ack_last, k == 16 && !ack_last});
            end
        end
        step();
        bus.m_mmu_cyc = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.s_mem_cyc, bus.m_mmu_err, bus.m_mmu_ack} !== 3'b000) begin
            bad++; $display("FAIL timeout_end_%0d actual=%b required=000", ack_last, {bus.s_mem_cyc, bus.m_mmu_err, bus.m_mmu_ack});
        end
    endtask

    task automatic test_reset_mid();
        step();
        bus.m_dma_cyc = 1'b1; bus.m_dma_we = 1'b1; bus.m_dma_addr = 32'h0000_F000; bus.m_dma_data_i = 32'hA5A5_0001;
        step();
        @(negedge clk);
        total++;
        if ({bus.s_dma_cyc, bus.s_we} !== 2'b11) begin bad++; $display("FAIL mid_gnt actual=%b required=11", {bus.s_dma_cyc, bus.s_we}); end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (all_outputs() !== 140'h0) begin bad++; $display("FAIL mid_reset_outputs actual=%h required=0", all_outputs()); end
        step();
        rst = 1'b0;
        bus.m_mmu_cyc = 1'b1; bus.m_mmu_we = 1'b0; bus.m_mmu_addr = 32'h0000_0400;
        step();
        @(negedge clk);
        total++;
        if ({bus.s_mem_cyc, bus.s_dma_cyc, bus.s_we, bus.s_addr} !== {3'b100, 32'h0000_0400}) begin
            bad++; $display("FAIL tie_after_reset actual=%b %h required=100 00000400", {bus.s_mem_cyc, bus.s_dma_cyc, bus.s_we}, bus.s_addr);
        end
        step();
        bus.m_mmu_cyc = 1'b0; bus.m_dma_cyc = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.s_mem_cyc, bus.m_mmu_ack, bus.m_mmu_err} !== 3'b000) begin
            bad++; $display("FAIL abort actual=%b required=000", {bus.s_mem_cyc, bus.m_mmu_ack, bus.m_mmu_err});
        end
    endtask

    initial begin
        bus.m_mmu_cyc = 1'b0; bus.m_mmu_we = 1'b0; bus.m_mmu_strb = 4'h0; bus.m_mmu_addr = 32'h0; bus.m_mmu_data_i = 32'h0;
        bus.m_dma_cyc = 1'b0; bus.m_dma_we = 1'b0; bus.m_dma_strb = 4'h0; bus.m_dma_addr = 32'h0; bus.m_dma_data_i = 32'h0;
        bus.s_mem_data_i = 32'h0; bus.s_dma_data_i = 32'h0; bus.s_key_data_i = 32'h0;
        test_reset();
        test_mmu_read();
        test_round_robin();
        test_key_write();
        test_unmapped();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
